// File: rtl/miriscv_rvfi_pkg.sv
// RVFI retirement record type and packing helper shared by the trace FIFO and its users.
package miriscv_rvfi_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_rec_t;

  localparam int unsigned RECORD_W = $bits(rvfi_rec_t);

  function automatic rvfi_rec_t pack_rvfi(
    input logic [63:0] order,
    input logic [31:0] insn,
    input logic        trap,
    input logic        halt,
    input logic        intr,
    input logic [31:0] pc_rdata,
    input logic [31:0] pc_wdata,
    input logic [4:0]  rd_addr,
    input logic [31:0] rd_wdata,
    input logic [31:0] mem_addr,
    input logic [3:0]  rmask,
    input logic [3:0]  wmask,
    input logic [31:0] mem_rdata,
    input logic [31:0] mem_wdata
  );
    rvfi_rec_t rec;
    rec.order     = order;
    rec.insn      = insn;
    rec.trap      = trap;
    rec.halt      = halt;
    rec.intr      = intr;
    rec.pc_rdata  = pc_rdata;
    rec.pc_wdata  = pc_wdata;
    rec.rd_addr   = rd_addr;
    rec.rd_wdata  = rd_wdata;
    rec.mem_addr  = mem_addr;
    rec.rmask     = rmask;
    rec.wmask     = wmask;
    rec.mem_rdata = mem_rdata;
    rec.mem_wdata = mem_wdata;
    return rec;
  endfunction

endpackage

// File: rtl/miriscv_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module miriscv_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             empty;
  logic             rd_en;
  logic             wr_en;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rd_en  = pop_i & ~empty;
  // When full, the slot freed by a simultaneous pop is reused by the push.
  assign wr_en  = push_i & (~full_o | rd_en);

  assign valid_o = ~empty;
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/miriscv_rvfi_trace_fifo.sv
// Buffers RVFI retirement records for a downstream checker, tracking drops, order
// continuity and halt.
module miriscv_rvfi_trace_fifo
  import miriscv_rvfi_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter bit          CHECK_ORDER = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rvfi_valid_i,
  input  logic [63:0]            rvfi_order_i,
  input  logic [31:0]            rvfi_insn_i,
  input  logic                   rvfi_trap_i,
  input  logic                   rvfi_halt_i,
  input  logic                   rvfi_intr_i,
  input  logic [31:0]            rvfi_pc_rdata_i,
  input  logic [31:0]            rvfi_pc_wdata_i,
  input  logic [4:0]             rvfi_rd_addr_i,
  input  logic [31:0]            rvfi_rd_wdata_i,
  input  logic [31:0]            rvfi_mem_addr_i,
  input  logic [3:0]             rvfi_mem_rmask_i,
  input  logic [3:0]             rvfi_mem_wmask_i,
  input  logic [31:0]            rvfi_mem_rdata_i,
  input  logic [31:0]            rvfi_mem_wdata_i,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output rvfi_rec_t              rec_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  output logic                   order_err_o,
  output logic [63:0]            err_exp_o,
  output logic [63:0]            err_got_o,
  output logic                   halted_o
);

  rvfi_rec_t            in_rec;
  logic [RECORD_W-1:0]  head;
  logic                 fifo_full;
  logic                 accept;
  logic                 pop;
  logic                 drop;
  logic                 halted_q;
  logic [CNT_W-1:0]     drop_cnt_q;

  assign in_rec = pack_rvfi(rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_halt_i, rvfi_intr_i,
                            rvfi_pc_rdata_i, rvfi_pc_wdata_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
                            rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i,
                            rvfi_mem_rdata_i, rvfi_mem_wdata_i);

  // Once halted, retirements are invisible to every part of this block.
  assign accept = rvfi_valid_i & ~halted_q;
  assign pop    = rec_valid_o & rec_ready_i;
  assign drop   = accept & fifo_full & ~pop;

  miriscv_sync_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .wdata_i (in_rec),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (rec_valid_o),
    .full_o  (fifo_full),
    .level_o (level_o)
  );

  assign rec_o      = rvfi_rec_t'(head);
  assign drop_cnt_o = drop_cnt_q;
  assign halted_o   = halted_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halted_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // A dropped halt record still halts capture.
      if (accept && rvfi_halt_i) halted_q <= 1'b1;
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  if (CHECK_ORDER) begin : g_order_chk
    logic [63:0] exp_order_q;
    logic        err_q;
    logic [63:0] err_exp_q;
    logic [63:0] err_got_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        exp_order_q <= '0;
        err_q       <= 1'b0;
        err_exp_q   <= '0;
        err_got_q   <= '0;
      end else if (accept) begin
        // Only the first mismatch is captured; the expectation always resyncs.
        if ((rvfi_order_i != exp_order_q) && !err_q) begin
          err_q     <= 1'b1;
          err_exp_q <= exp_order_q;
          err_got_q <= rvfi_order_i;
        end
        exp_order_q <= rvfi_order_i + 64'd1;
      end
    end

    assign order_err_o = err_q;
    assign err_exp_o   = err_exp_q;
    assign err_got_o   = err_got_q;
  end else begin : g_no_order_chk
    assign order_err_o = 1'b0;
    assign err_exp_o   = '0;
    assign err_got_o   = '0;
  end

endmodule

// File: tb/tb_miriscv_rvfi_trace_fifo.sv
// Scoreboard bench for the RVFI trace FIFO: expected records are queued as they are retired
// and compared as they leave the FIFO.
module tb_miriscv_rvfi_trace_fifo;
  import miriscv_rvfi_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rvfi_valid = 1'b0;
  rvfi_rec_t         drv = '0;
  logic              rec_valid;
  logic              rec_ready = 1'b0;
  rvfi_rec_t         rec;
  logic [4:0]        level;
  logic [CNT_W-1:0]  drop_cnt;
  logic              order_err;
  logic [63:0]       err_exp;
  logic [63:0]       err_got;
  logic              halted;

  int n_checks = 0;
  int n_fail   = 0;
  rvfi_rec_t exp_q[$];

  always #5 clk = ~clk;

  miriscv_rvfi_trace_fifo #(
    .DEPTH       (DEPTH),
    .CHECK_ORDER (1'b1),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rvfi_valid_i     (rvfi_valid),
    .rvfi_order_i     (drv.order),
    .rvfi_insn_i      (drv.insn),
    .rvfi_trap_i      (drv.trap),
    .rvfi_halt_i      (drv.halt),
    .rvfi_intr_i      (drv.intr),
    .rvfi_pc_rdata_i  (drv.pc_rdata),
    .rvfi_pc_wdata_i  (drv.pc_wdata),
    .rvfi_rd_addr_i   (drv.rd_addr),
    .rvfi_rd_wdata_i  (drv.rd_wdata),
    .rvfi_mem_addr_i  (drv.mem_addr),
    .rvfi_mem_rmask_i (drv.rmask),
    .rvfi_mem_wmask_i (drv.wmask),
    .rvfi_mem_rdata_i (drv.mem_rdata),
    .rvfi_mem_wdata_i (drv.mem_wdata),
    .rec_valid_o      (rec_valid),
    .rec_ready_i      (rec_ready),
    .rec_o            (rec),
    .level_o          (level),
    .drop_cnt_o       (drop_cnt),
    .order_err_o      (order_err),
    .err_exp_o        (err_exp),
    .err_got_o        (err_got),
    .halted_o         (halted)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic rvfi_rec_t mk_rec(input logic [63:0] ord, input logic halt);
    rvfi_rec_t r;
    r.order     = ord;
    r.insn      = $urandom;
    r.trap      = 1'($urandom);
    r.halt      = halt;
    r.intr      = 1'($urandom);
    r.pc_rdata  = $urandom;
    r.pc_wdata  = $urandom;
    r.rd_addr   = 5'($urandom);
    r.rd_wdata  = $urandom;
    r.mem_addr  = $urandom;
    r.rmask     = 4'($urandom);
    r.wmask     = 4'($urandom);
    r.mem_rdata = $urandom;
    r.mem_wdata = $urandom;
    return r;
  endfunction

  // Drive one retirement for a single cycle; kept=1 means it must come out of the FIFO.
  task automatic retire(input logic [63:0] ord, input logic halt, input bit kept);
    rvfi_rec_t r;
    r = mk_rec(ord, halt);
    drv = r;
    rvfi_valid = 1'b1;
    if (kept) exp_q.push_back(r);
    @(posedge clk);
    #1;
    rvfi_valid = 1'b0;
  endtask

  task automatic do_reset();
    rec_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compare every accepted record against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_rec", 64'(exp_q.size()), 64'd1);
      end else begin
        rvfi_rec_t e;
        e = exp_q.pop_front();
        check_val("rec_order", rec.order, e.order);
        check_val("rec_fields", 64'(rec == e), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_valid", 64'(rec_valid), 64'd0);
    check_val("rst_level", 64'(level), 64'd0);
    check_val("rst_drop", 64'(drop_cnt), 64'd0);
    check_val("rst_err", 64'(order_err), 64'd0);
    check_val("rst_halt", 64'(halted), 64'd0);

    // Streaming with ready held high: one-cycle latency, level never above 1.
    rec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      retire(64'(i), 1'b0, 1'b1);
      check_val("stream_valid", 64'(rec_valid), 64'd1);
      check_val("stream_level", 64'(level), 64'd1);
    end
    wait_drain("stream_drain");
    check_val("stream_err", 64'(order_err), 64'd0);
    check_val("stream_empty", 64'(rec_valid), 64'd0);

    // Overflow: 20 retires into a 16-deep FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 20; i++) retire(64'(i), 1'b0, i < 16);
    check_val("ovf_level", 64'(level), 64'd16);
    check_val("ovf_drop", 64'(drop_cnt), 64'd4);
    check_val("ovf_err", 64'(order_err), 64'd0);
    rec_ready = 1'b1;
    wait_drain("ovf_drain");
    check_val("ovf_empty", 64'(rec_valid), 64'd0);
    check_val("ovf_level0", 64'(level), 64'd0);

    // Push and pop together while full: slot reused, level unchanged.
    do_reset();
    for (int i = 0; i < 16; i++) retire(64'(i), 1'b0, 1'b1);
    check_val("full_level", 64'(level), 64'd16);
    rec_ready = 1'b1;
    retire(64'd16, 1'b0, 1'b1);
    check_val("full_pp_level", 64'(level), 64'd16);
    check_val("full_pp_drop", 64'(drop_cnt), 64'd0);
    wait_drain("full_drain");

    // Order gaps: only the first mismatch is captured.
    do_reset();
    rec_ready = 1'b1;
    retire(64'd0, 1'b0, 1'b1);
    retire(64'd1, 1'b0, 1'b1);
    retire(64'd2, 1'b0, 1'b1);
    check_val("gap_noerr", 64'(order_err), 64'd0);
    retire(64'd5, 1'b0, 1'b1);
    check_val("gap_err", 64'(order_err), 64'd1);
    retire(64'd6, 1'b0, 1'b1);
    retire(64'd9, 1'b0, 1'b1);
    wait_drain("gap_drain");
    check_val("gap_err_sticky", 64'(order_err), 64'd1);
    check_val("gap_exp", err_exp, 64'd3);
    check_val("gap_got", err_got, 64'd5);

    // Halt: records after the halt record are ignored entirely.
    do_reset();
    rec_ready = 1'b1;
    retire(64'd0, 1'b0, 1'b1);
    retire(64'd1, 1'b0, 1'b1);
    retire(64'd2, 1'b0, 1'b1);
    check_val("halt_pre", 64'(halted), 64'd0);
    retire(64'd3, 1'b1, 1'b1);
    check_val("halt_set", 64'(halted), 64'd1);
    retire(64'd4, 1'b0, 1'b0);
    retire(64'd9, 1'b0, 1'b0);
    wait_drain("halt_drain");
    check_val("halt_empty", 64'(rec_valid), 64'd0);
    check_val("halt_drop", 64'(drop_cnt), 64'd0);
    check_val("halt_err", 64'(order_err), 64'd0);
    check_val("halt_sticky", 64'(halted), 64'd1);

    // Reset mid-stream discards buffered records and clears all state.
    do_reset();
    for (int i = 0; i < 20; i++) retire(64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) retire(64'(i), 1'b0, 1'b0);
    check_val("mid_level", 64'(level), 64'd16);
    check_val("mid_err_pre", 64'(order_err), 64'd1);
    do_reset();
    check_val("mid_rst_level", 64'(level), 64'd0);
    check_val("mid_rst_valid", 64'(rec_valid), 64'd0);
    check_val("mid_rst_drop", 64'(drop_cnt), 64'd0);
    check_val("mid_rst_err", 64'(order_err), 64'd0);
    check_val("mid_rst_exp", err_exp, 64'd0);
    check_val("mid_rst_got", err_got, 64'd0);
    for (int i = 0; i < 7; i++) retire(64'(i), 1'b0, 1'b0);
    check_val("seven_level", 64'(level), 64'd7);
    do_reset();
    check_val("seven_rst_level", 64'(level), 64'd0);
    check_val("seven_rst_valid", 64'(rec_valid), 64'd0);
    rec_ready = 1'b1;
    retire(64'd0, 1'b0, 1'b1);
    wait_drain("post_rst_drain");
    check_val("post_rst_err", 64'(order_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
